i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target_if.sv | 29 ++
 rtl/i2c_target.sv | 198 +++++++++++++++++++
 tb/tb_i2c_target.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// i2c_target_if: bundles the raw I2C pins and the register-file port of the I2C target.
//   scl_i, sda_i : raw bus levels seen by the target
//   sda_oe       : open-drain pull-down request from the target (1 = drive SDA low)
//   busy         : transaction in progress (START seen, STOP not yet)
//   wr_en/wr_addr/wr_data : one-clk register write strobe with index and data
//   rd_addr/rd_data       : register read index and same-cycle read data
// Modports: slave = the target block, master = the environment (bus + register file).
`timescale 1ns / 1ps
interface i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       busy;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport slave (
    input  scl_i, sda_i, rd_data,
    output sda_oe, busy, wr_en, wr_addr, wr_data, rd_addr
  );

  modport master (
    output scl_i, sda_i, rd_data,
    input  sda_oe, busy, wr_en, wr_addr, wr_data, rd_addr
  );
endinterface

// File: rtl/i2c_target.sv
// i2c_target: 7-bit-addressed I2C target with an 8-bit auto-incrementing register pointer.
// The first byte written after the address loads the pointer; later written bytes are
// issued as register writes. Reads return rd_data for the current pointer, MSB first.
// Ports:
//   clk  : system clock (>= 16x SCL)
//   rst  : asynchronous active-high reset
//   bus  : i2c_target_if.slave (pins, busy, register write/read port)
`timescale 1ns / 1ps
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  i2c_target_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StWaitStop
  } state_e;

  // Synchronisers reset to 1 so an idle bus produces no spurious edges.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= (scl_sync_q << 1) | SYNC_STAGES'(bus.scl_i);
      sda_sync_q <= (sda_sync_q << 1) | SYNC_STAGES'(bus.sda_i);
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] ptr_q;
  logic       rw_q;
  logic       first_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic       wr_en_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;

  logic [7:0] byte_in;
  assign byte_in = {shift_q[6:0], sda_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= 8'h00;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      wr_en_q <= 1'b0;
      if (start_det) begin
        state_q   <= StAddr;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_det) begin
        state_q   <= StIdle;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StAddr: begin
            if (scl_rise) begin
              shift_q <= byte_in;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                if (shift_q[6:0] == DEV_ADDR) begin
                  state_q <= StAddrAck;
                  rw_q    <= sda_s;
                  first_q <= 1'b1;
                end else begin
                  state_q <= StWaitStop;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          // bit_cnt: 0 = wait fall to drive ACK, 1 = wait 9th rise, 2 = wait fall to release.
          StAddrAck, StWrAck: begin
            if (scl_fall && bit_cnt_q == 4'd0) begin
              sda_oe_q  <= 1'b1;
              bit_cnt_q <= 4'd1;
            end else if (scl_rise && bit_cnt_q == 4'd1) begin
              bit_cnt_q <= 4'd2;
            end else if (scl_fall && bit_cnt_q == 4'd2) begin
              if (state_q == StAddrAck && rw_q) begin
                // First read bit goes out on the same edge that ends the ACK.
                state_q   <= StRdByte;
                shift_q   <= bus.rd_data;
                sda_oe_q  <= ~bus.rd_data[7];
                bit_cnt_q <= 4'd1;
              end else begin
                state_q   <= StWrByte;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
              end
            end
          end

          StWrByte: begin
            if (scl_rise) begin
              shift_q <= byte_in;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                state_q   <= StWrAck;
                if (first_q) begin
                  ptr_q   <= byte_in;
                  first_q <= 1'b0;
                end else begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= ptr_q;
                  wr_data_q <= byte_in;
                  ptr_q     <= ptr_q + 8'd1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          // bit_cnt counts bits already driven; after 8 the next fall frees SDA for the ACK.
          StRdByte: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                state_q   <= StRdAck;
              end else begin
                shift_q   <= {shift_q[6:0], 1'b0};
                sda_oe_q  <= ~shift_q[6];
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          // The pointer advances past every byte handed out, acknowledged or not.
          StRdAck: begin
            if (scl_rise && bit_cnt_q == 4'd0) begin
              ptr_q <= ptr_q + 8'd1;
              if (sda_s) begin
                state_q <= StWaitStop;
              end else begin
                bit_cnt_q <= 4'd1;
              end
            end else if (scl_fall && bit_cnt_q == 4'd1) begin
              state_q   <= StRdByte;
              shift_q   <= bus.rd_data;
              sda_oe_q  <= ~bus.rd_data[7];
              bit_cnt_q <= 4'd1;
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_addr = ptr_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C master plus register-file model around i2c_target.
`timescale 1ns / 1ps
module tb_i2c_target;
  localparam int Q = 80;  // quarter SCL period in ns (SCL period 320 ns, clk 10 ns)

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] mem [256];

  i2c_target_if bus ();

  i2c_target #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic sda_line;
  assign sda_line     = m_sda & ~bus.sda_oe;
  assign bus.scl_i    = m_scl;
  assign bus.sda_i    = sda_line;
  assign bus.rd_data  = mem[bus.rd_addr];

  always #5 clk = ~clk;

  // Observers: log every write strobe cycle and count cycles with SDA pulled low.
  logic [15:0] wr_log [$];
  int          oe_cnt = 0;
  always @(negedge clk) begin
    if (bus.wr_en) wr_log.push_back({bus.wr_addr, bus.wr_data});
    if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [15:0] exp);
    logic [15:0] e;
    e = (idx < wr_log.size()) ? wr_log[idx] : 16'hxxxx;
    check(tag, {16'h0, e}, {16'h0, exp});
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q;
    m_scl = 1'b1; #(2 * Q);
    m_scl = 1'b0; #Q;
  endtask

  // Sends 8 bits and returns the sampled ACK level (0 = ACK).
  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    ack = sda_line; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic do_ack);
    b = 8'h00;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #Q; m_scl = 1'b1;
      #Q; b = {b[6:0], sda_line};
      #Q; m_scl = 1'b0;
      #Q;
    end
    m_sda = ~do_ack; #Q;
    m_scl = 1'b1; #(2 * Q);
    m_scl = 1'b0; #Q;
    m_sda = 1'b1;
  endtask

  logic       ack;
  logic [7:0] rb;
  int         base;
  int         oe_base;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
    mem[8'h00] = 8'h96;
    mem[8'h01] = 8'h3C;
    mem[8'h10] = 8'h5A;
    mem[8'h11] = 8'hC3;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_oe", {31'h0, bus.sda_oe}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_wr_en", {31'h0, bus.wr_en}, 32'h0);
    check("rst_wr_addr", {24'h0, bus.wr_addr}, 32'h0);
    check("rst_wr_data", {24'h0, bus.wr_data}, 32'h0);
    check("rst_rd_addr", {24'h0, bus.rd_addr}, 32'h0);
    rst = 1'b0;
    #(4 * Q);

    // Write: pointer 0x05 then data 0x3C, 0x7E
    base = wr_log.size();
    i2c_start();
    check("wr_busy_after_start", {31'h0, bus.busy}, 32'h1);
    send_byte(8'hA0, ack); check("wr_ack_addr", {31'h0, ack}, 32'h0);
    send_byte(8'h05, ack); check("wr_ack_ptr", {31'h0, ack}, 32'h0);
    send_byte(8'h3C, ack); check("wr_ack_d0", {31'h0, ack}, 32'h0);
    send_byte(8'h7E, ack); check("wr_ack_d1", {31'h0, ack}, 32'h0);
    i2c_stop();
    #Q;
    check("wr_count", wr_log.size() - base, 32'd2);
    check_wr("wr_first", base, 16'h053C);
    check_wr("wr_second", base + 1, 16'h067E);
    check("wr_busy_after_stop", {31'h0, bus.busy}, 32'h0);
    check("wr_rd_addr", {24'h0, bus.rd_addr}, 32'h07);

    // Read with repeated START
    base = wr_log.size();
    i2c_start();
    send_byte(8'hA0, ack); check("rd_ack_waddr", {31'h0, ack}, 32'h0);
    send_byte(8'h10, ack); check("rd_ack_ptr", {31'h0, ack}, 32'h0);
    i2c_start();
    send_byte(8'hA1, ack); check("rd_ack_raddr", {31'h0, ack}, 32'h0);
    recv_byte(rb, 1'b1); check("rd_byte0", {24'h0, rb}, 32'h5A);
    recv_byte(rb, 1'b0); check("rd_byte1", {24'h0, rb}, 32'hC3);
    check("rd_oe_after_nack", {31'h0, bus.sda_oe}, 32'h0);
    i2c_stop();
    #Q;
    check("rd_rd_addr", {24'h0, bus.rd_addr}, 32'h12);
    check("rd_no_wr", wr_log.size() - base, 32'd0);
    check("rd_busy_after_stop", {31'h0, bus.busy}, 32'h0);

    // Address mismatch
    base = wr_log.size();
    oe_base = oe_cnt;
    i2c_start();
    send_byte(8'hA2, ack); check("mm_nack_addr", {31'h0, ack}, 32'h1);
    send_byte(8'h11, ack); check("mm_nack_data", {31'h0, ack}, 32'h1);
    i2c_stop();
    #Q;
    check("mm_oe_never", oe_cnt - oe_base, 32'd0);
    check("mm_no_wr", wr_log.size() - base, 32'd0);
    check("mm_ptr_kept", {24'h0, bus.rd_addr}, 32'h12);

    // Pointer wrap
    base = wr_log.size();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h01, ack); check("wrap_ack_d0", {31'h0, ack}, 32'h0);
    send_byte(8'h02, ack); check("wrap_ack_d1", {31'h0, ack}, 32'h0);
    i2c_stop();
    #Q;
    check("wrap_count", wr_log.size() - base, 32'd2);
    check_wr("wrap_first", base, 16'hFF01);
    check_wr("wrap_second", base + 1, 16'h0002);
    check("wrap_rd_addr", {24'h0, bus.rd_addr}, 32'h01);

    // Reset in the middle of a read byte (mem[0x01] MSB is 0, so SDA is pulled low)
    i2c_start();
    send_byte(8'hA1, ack); check("rr_ack_addr", {31'h0, ack}, 32'h0);
    check("rr_oe_driving", {31'h0, bus.sda_oe}, 32'h1);
    rst = 1'b1;
    #1;
    check("rr_oe_async", {31'h0, bus.sda_oe}, 32'h0);
    check("rr_ptr_reset", {24'h0, bus.rd_addr}, 32'h0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    #Q;
    rst = 1'b0;
    #(2 * Q);
    check("rr_busy_idle", {31'h0, bus.busy}, 32'h0);
    i2c_start();
    send_byte(8'hA1, ack); check("rr_ack_addr2", {31'h0, ack}, 32'h0);
    recv_byte(rb, 1'b0); check("rr_byte_addr0", {24'h0, rb}, 32'h96);
    i2c_stop();
    #Q;
    check("rr_rd_addr", {24'h0, bus.rd_addr}, 32'h01);

    // Abort: STOP after 4 bits of a data byte
    base = wr_log.size();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h20, ack); check("ab_ack_ptr", {31'h0, ack}, 32'h0);
    for (int i = 7; i >= 4; i--) send_bit(i[0]);
    i2c_stop();
    #Q;
    check("ab_no_wr", wr_log.size() - base, 32'd0);
    check("ab_busy", {31'h0, bus.busy}, 32'h0);
    check("ab_rd_addr", {24'h0, bus.rd_addr}, 32'h20);
    check("ab_oe", {31'h0, bus.sda_oe}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
